// File: rtl/text_overlay.sv
// Character-cell text overlay: cursor-driven character buffer with a
// combinational per-pixel font lookup for the color mapper.
module text_overlay #(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 30,
  parameter logic [6:0] FILL_CHAR = 7'h20
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        text_en,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic [10:0] font_addr,
  output logic [3:0]  text_offset,
  output logic        draw_text,
  output logic        busy,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);

  localparam logic [1:0] OP_PUTC  = 2'd0;
  localparam logic [1:0] OP_SETC  = 2'd1;
  localparam logic [1:0] OP_SETR  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);
  localparam logic [6:0]    LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]    LAST_ROW  = 5'(ROWS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state, state_d;
  logic [AW-1:0] clr_addr, clr_d;
  logic [6:0]    col_d;
  logic [4:0]    row_d, row_adv;

  logic          we;
  logic [AW-1:0] wa;
  logic [6:0]    wd;

  logic [6:0]    mem [CELLS];

  logic          in_grid;
  logic [AW-1:0] rd_idx;
  logic [6:0]    rd_char;
  logic          accept;

  assign busy      = (state == CLEAR);
  assign cmd_ready = (state == IDLE) && !Reset;
  assign accept    = cmd_valid && cmd_ready;
  assign row_adv   = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;

  always_comb begin
    state_d = state;
    clr_d   = clr_addr;
    col_d   = cursor_col;
    row_d   = cursor_row;
    we      = 1'b0;
    wa      = '0;
    wd      = '0;
    unique case (state)
      CLEAR: begin
        we = 1'b1;
        wa = clr_addr;
        wd = FILL_CHAR;
        if (clr_addr == LAST_ADDR) begin
          state_d = IDLE;
          col_d   = 7'd0;
          row_d   = 5'd0;
        end else begin
          clr_d = clr_addr + AW'(1);
        end
      end
      IDLE: begin
        if (accept) begin
          unique case (cmd_op)
            OP_PUTC: begin
              if (cmd_data[6:0] == 7'h0A) begin
                col_d = 7'd0;
                row_d = row_adv;
              end else begin
                we = 1'b1;
                wa = AW'(AW'(cursor_row) * AW'(COLS) + AW'(cursor_col));
                wd = cmd_data[6:0];
                if (cursor_col == LAST_COL) begin
                  col_d = 7'd0;
                  row_d = row_adv;
                end else begin
                  col_d = cursor_col + 7'd1;
                end
              end
            end
            OP_SETC: col_d = (cmd_data > 8'(COLS - 1)) ? LAST_COL : cmd_data[6:0];
            OP_SETR: row_d = (cmd_data > 8'(ROWS - 1)) ? LAST_ROW : cmd_data[4:0];
            OP_CLEAR: begin
              state_d = CLEAR;
              clr_d   = '0;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      cursor_col <= 7'd0;
      cursor_row <= 5'd0;
    end else begin
      state      <= state_d;
      clr_addr   <= clr_d;
      cursor_col <= col_d;
      cursor_row <= row_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (we && !Reset)
      mem[wa] <= wd;
  end

  // Same-pixel read: color_mapper samples font_data in this pixel.
  assign in_grid = (DrawX < 10'(COLS * 8)) && (DrawY < 10'(ROWS * 16));
  assign rd_idx  = in_grid ?
                   AW'(AW'(DrawY[9:4]) * AW'(COLS) + AW'(DrawX[9:3])) : '0;
  assign rd_char = mem[rd_idx];

  assign font_addr   = {rd_char, DrawY[3:0]};
  assign text_offset = {1'b0, 3'd7 - DrawX[2:0]};
  assign draw_text   = text_en && !busy && in_grid;

endmodule

// File: tb/tb_text_overlay.sv
// Directed vector bench for text_overlay: clear timing, cursor
// commands, buffer contents via the pixel read path, grid bounds.
module tb_text_overlay;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        text_en;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic [10:0] font_addr;
  logic [3:0]  text_offset;
  logic        draw_text;
  logic        busy;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  int checks = 0;
  int errors = 0;

  text_overlay dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .text_en(text_en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .font_addr(font_addr),
    .text_offset(text_offset), .draw_text(draw_text), .busy(busy),
    .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts cycles until busy drops; bounded.
  task automatic wait_clear(output int n, output int bad);
    n = 0;
    bad = 0;
    while (busy && n < 3000) begin
      if (cmd_ready || draw_text) bad++;
      @(posedge Clk);
      #1;
      n++;
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    int x, y, col, row, ch;
  } cmd_vec_t;

  typedef struct {
    int x, y;
    logic en;
    logic full;
    int fa, off, dt;
  } pix_vec_t;

  cmd_vec_t cv[17];
  pix_vec_t pv[9];

  initial begin
    int n, bad;

    cv[0]  = '{2'd0, 8'h41,   3,   5,  1,  0, 'h41};
    cv[1]  = '{2'd1, 8'hC8,   0,   0, 79,  0, 'h41};
    cv[2]  = '{2'd2, 8'h1D, 639, 479, 79, 29, 'h20};
    cv[3]  = '{2'd0, 8'h5A, 639, 479,  0,  0, 'h5A};
    cv[4]  = '{2'd1, 8'h0A,  80,   0, 10,  0, 'h20};
    cv[5]  = '{2'd0, 8'h0A,  80,   0,  0,  1, 'h20};
    cv[6]  = '{2'd2, 8'h1D,  80, 464,  0, 29, 'h20};
    cv[7]  = '{2'd1, 8'h0A,  80, 464, 10, 29, 'h20};
    cv[8]  = '{2'd0, 8'h8A,  80, 464,  0,  0, 'h20};
    cv[9]  = '{2'd0, 8'hC2,   0,   0,  1,  0, 'h42};
    cv[10] = '{2'd2, 8'h1F,   8,   0,  1, 29, 'h20};
    cv[11] = '{2'd0, 8'h43,  15, 479,  2, 29, 'h43};
    cv[12] = '{2'd1, 8'h4F,  15, 479, 79, 29, 'h43};
    cv[13] = '{2'd0, 8'h44, 639, 479,  0,  0, 'h44};
    cv[14] = '{2'd1, 8'h4F, 632,  80, 79,  0, 'h20};
    cv[15] = '{2'd2, 8'h05, 632,  80, 79,  5, 'h20};
    cv[16] = '{2'd0, 8'h45, 632,  80,  0,  6, 'h45};

    pv[0] = '{   3,    5, 1'b1, 1'b1, 'h425, 4, 1};
    pv[1] = '{ 639,  479, 1'b1, 1'b1, 'h44F, 0, 1};
    pv[2] = '{ 640,    0, 1'b1, 1'b0, 0, 0, 0};
    pv[3] = '{   0,  480, 1'b1, 1'b0, 0, 0, 0};
    pv[4] = '{ 639,  479, 1'b0, 1'b1, 'h44F, 0, 0};
    pv[5] = '{   8,  470, 1'b1, 1'b1, 'h436, 7, 1};
    pv[6] = '{ 633,   85, 1'b1, 1'b1, 'h455, 6, 1};
    pv[7] = '{1023, 1023, 1'b1, 1'b0, 0, 0, 0};
    pv[8] = '{ 100,  100, 1'b0, 1'b1, 'h204, 3, 0};

    Reset = 1'b1;
    DrawX = 10'd3;
    DrawY = 10'd5;
    text_en = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_data = 8'd0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_ready", int'(cmd_ready), 0);
    chk("reset_busy", int'(busy), 1);
    chk("reset_col", int'(cursor_col), 0);
    chk("reset_row", int'(cursor_row), 0);
    chk("reset_draw", int'(draw_text), 0);
    Reset = 1'b0;
    wait_clear(n, bad);
    chk("clear_len", n, 2400);
    chk("clear_ready_low", bad, 0);
    chk("idle_ready", int'(cmd_ready), 1);
    DrawX = 10'd17;
    DrawY = 10'd37;
    #1;
    chk("fill_fa", int'(font_addr), 'h205);

    foreach (cv[i]) begin
      chk($sformatf("cmd%0d_ready", i), int'(cmd_ready), 1);
      cmd_op = cv[i].op;
      cmd_data = cv[i].data;
      cmd_valid = 1'b1;
      @(posedge Clk);
      #1;
      cmd_valid = 1'b0;
      DrawX = 10'(cv[i].x);
      DrawY = 10'(cv[i].y);
      #1;
      chk($sformatf("cmd%0d_col", i), int'(cursor_col), cv[i].col);
      chk($sformatf("cmd%0d_row", i), int'(cursor_row), cv[i].row);
      chk($sformatf("cmd%0d_char", i), int'(font_addr[10:4]), cv[i].ch);
    end

    foreach (pv[i]) begin
      DrawX = 10'(pv[i].x);
      DrawY = 10'(pv[i].y);
      text_en = pv[i].en;
      #1;
      chk($sformatf("pix%0d_draw", i), int'(draw_text), pv[i].dt);
      if (pv[i].full) begin
        chk($sformatf("pix%0d_fa", i), int'(font_addr), pv[i].fa);
        chk($sformatf("pix%0d_off", i), int'(text_offset), pv[i].off);
      end
    end

    // CLEAR, reset at clear cycle 1000, PUTC held valid throughout.
    text_en = 1'b1;
    DrawX = 10'd3;
    DrawY = 10'd5;
    cmd_op = 2'd3;
    cmd_valid = 1'b1;
    @(posedge Clk);
    #1;
    cmd_op = 2'd0;
    cmd_data = 8'h51;
    chk("clr_busy", int'(busy), 1);
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      if (cmd_ready || draw_text || !busy || cursor_row != 5'd6) bad++;
      @(posedge Clk);
      #1;
    end
    chk("clr_mid_hold", bad, 0);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    chk("clr_rst_cursor", int'(cursor_row), 0);
    wait_clear(n, bad);
    chk("clr_restart_len", n, 2400);
    chk("clr_restart_ready", bad, 0);
    chk("clr_not_taken", int'(cursor_col), 0);
    chk("clr_done_ready", int'(cmd_ready), 1);
    @(posedge Clk);
    #1;
    cmd_valid = 1'b0;
    chk("held_taken_col", int'(cursor_col), 1);
    DrawX = 10'd0;
    DrawY = 10'd0;
    #1;
    chk("held_char", int'(font_addr[10:4]), 'h51);
    DrawX = 10'd639;
    DrawY = 10'd479;
    #1;
    chk("clr_last_cell", int'(font_addr[10:4]), 'h20);
    DrawX = 10'd633;
    DrawY = 10'd85;
    #1;
    chk("clr_mid_cell", int'(font_addr[10:4]), 'h20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/text_overlay.md
Name: text_overlay

Overview:
- Owns the on-screen character buffer and produces the per-pixel text lookup consumed by color_mapper: font_addr, text_offset and draw_text.
- A command port driven by the NIOS-side PIO glue writes characters at a hardware-managed cursor, repositions the cursor, or clears the screen.
- The character grid is COLS x ROWS cells of 8x16 pixels, anchored at screen pixel (0,0).

Parameters:
- COLS, 80, characters per row (8 px each).
- ROWS, 30, character rows (16 px each).
- FILL_CHAR, 7'h20, code written to every cell by a clear.

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current pixel X from the VGA controller.
- DrawY  in  10  current pixel Y from the VGA controller.
- text_en  in  1  global text display enable.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block accepts a command this cycle.
- cmd_op  in  2  command: 0 PUTC, 1 SET_COL, 2 SET_ROW, 3 CLEAR.
- cmd_data  in  8  character code or coordinate.
- font_addr  out  11  font ROM address, {char[6:0], DrawY[3:0]}.
- text_offset  out  4  bit index into font_data, 7 - DrawX[2:0].
- draw_text  out  1  current pixel lies inside the text grid and text is visible.
- busy  out  1  clear in progress.
- cursor_col  out  7  current cursor column.
- cursor_row  out  5  current cursor row.

Behaviour:
- Buffer: COLS*ROWS x 7-bit entries, one write port, one read port.
- Read path is combinational from DrawX/DrawY, with no pipeline delay, because color_mapper samples font_data in the same pixel.
  - Index = (DrawY>>4)*COLS + (DrawX>>3).
- draw_text = text_en && !busy && DrawX < COLS*8 && DrawY < ROWS*16.
- Outside the grid, font_addr and text_offset are don't-care, but the read index must not go out of range: clamp it to 0.
- Handshake: a command is accepted on the rising edge when cmd_valid && cmd_ready. cmd_ready = (state==IDLE) && !Reset. cmd_op and cmd_data are sampled only on acceptance.
- FSM states: IDLE, CLEAR.
  - Reset (any state, any cycle) -> CLEAR with clr_addr=0, cursor=(0,0). A reset mid-clear restarts the clear from 0.
  - In CLEAR: write FILL_CHAR to clr_addr each cycle; clr_addr increments.
  - When clr_addr == COLS*ROWS-1 is written -> IDLE, cursor=(0,0).
  - A clear takes exactly COLS*ROWS cycles; busy=1 throughout.
  - IDLE + accepted CLEAR -> CLEAR with clr_addr=0 on the next cycle.
- PUTC:
  - cmd_data[6:0] == 7'h0A (newline): no write; col=0, row advances.
  - Otherwise: write cmd_data[6:0] (bit 7 ignored) at (row,col); col advances.
  - Col advance: col==COLS-1 -> col=0 and row advances, else col+1.
  - Row advance: row==ROWS-1 -> row=0 (wrap to top, no scroll), else row+1.
  - The written character is visible on the read path from the cycle after acceptance.
- SET_COL: col = min(cmd_data, COLS-1). SET_ROW: row = min(cmd_data, ROWS-1). The other coordinate is unchanged.
- Reset values: cmd_ready=0 while Reset is high, then 0 during the clear; busy=1; cursor_col=0; cursor_row=0; draw_text=0 (busy). Buffer contents are defined only after the clear completes.
- Write-port priority: the clear writes and PUTC writes are mutually exclusive because cmd_ready=0 in CLEAR. There are no simultaneous writers.
- Arithmetic: the index multiply uses a constant COLS, so shift-add is acceptable. All comparisons are unsigned 10-bit.

Test Plan:
1. Release Reset, hold cmd_valid=0.
   - Required: busy=1 and cmd_ready=0 for exactly 2400 cycles, then busy=0 and cmd_ready=1.
   - Sampling any grid pixel then gives font_addr={7'h20, DrawY[3:0]}.
2. PUTC 'A' (8'h41) at (0,0).
   - Required: cursor becomes (1,0).
   - DrawX=3, DrawY=5 gives font_addr=11'h415, text_offset=4, draw_text=1 (text_en=1).
3. SET_COL 79, SET_ROW 29, then PUTC 'Z'.
   - Required: 'Z' is stored at cell 2399 and the cursor wraps to (0,0).
   - SET_COL 200 results in cursor_col=79.
4. SET_COL 10, then PUTC 8'h0A.
   - Required: cursor=(0,row+1) and buffer cell (row,10) is unchanged.
   - The same command with row=29 gives row=0.
5. Issue CLEAR, then assert Reset for one cycle at clear cycle 1000.
   - Required: the clear restarts at clr_addr=0 and busy lasts a further 2400 cycles.
   - cmd_valid held high throughout is not accepted until busy=0.
6. Check draw_text boundaries with text_en=1.
   - Required: draw_text=0 at DrawX=640 or DrawY=480 and 1 at (639,479).
   - text_en=0 forces draw_text=0 everywhere.
